ram_bist: RTL and testbench

RAM_BIST -- requirements
Module: ram_bist

---
 rtl/ram_bist.sv | 160 ++++++++++++++++
 tb/tb_ram_bist.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ram_bist.sv
// March C-lite memory BIST controller: drives a synchronous RAM with registered
// read data, compares every read one cycle later and records mismatches.
module ram_bist #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH+1:0] err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data
);

  typedef enum logic [3:0] {
    IDLE, M0, M1_R, M1_W, M2_R, M2_W, M3_R, DRAIN, DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    pend_q, pend_d;
  logic [DATA_WIDTH-1:0]   exp_q, exp_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [ADDR_WIDTH+1:0]   err_q, err_d;
  logic [ADDR_WIDTH-1:0]   faddr_q, faddr_d;
  logic [DATA_WIDTH-1:0]   fdata_q, fdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pend_q  <= 1'b0;
      exp_q   <= '0;
      paddr_q <= '0;
      err_q   <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      exp_q   <= exp_d;
      paddr_q <= paddr_d;
      err_q   <= err_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    pend_d    = 1'b0;
    exp_d     = exp_q;
    paddr_d   = paddr_q;
    err_d     = err_q;
    faddr_d   = faddr_q;
    fdata_d   = fdata_q;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;

    // Compare the read issued in the previous cycle; the first mismatch is
    // recognised by the counter still being zero (cleared at every start).
    if (pend_q && (ram_rdata != exp_q)) begin
      if (err_q != '1) err_d = err_q + 1'b1;
      if (err_q == '0) begin
        faddr_d = paddr_q;
        fdata_d = ram_rdata;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = M0;
          addr_d  = '0;
          err_d   = '0;
          faddr_d = '0;
          fdata_d = '0;
        end
      end
      M0: begin
        ram_we    = 1'b1;
        ram_addr  = addr_q;
        ram_wdata = '0;
        if (addr_q == ADDR_MAX) begin
          state_d = M1_R;
          addr_d  = '0;
        end else begin
          addr_d  = addr_q + 1'b1;
        end
      end
      M1_R: begin
        ram_addr = addr_q;
        pend_d   = 1'b1;
        exp_d    = '0;
        paddr_d  = addr_q;
        state_d  = M1_W;
      end
      M1_W: begin
        ram_we    = 1'b1;
        ram_addr  = addr_q;
        ram_wdata = '1;
        if (addr_q == ADDR_MAX) begin
          state_d = M2_R;
        end else begin
          state_d = M1_R;
          addr_d  = addr_q + 1'b1;
        end
      end
      M2_R: begin
        ram_addr = addr_q;
        pend_d   = 1'b1;
        exp_d    = '1;
        paddr_d  = addr_q;
        state_d  = M2_W;
      end
      M2_W: begin
        ram_we    = 1'b1;
        ram_addr  = addr_q;
        ram_wdata = '0;
        if (addr_q == '0) begin
          state_d = M3_R;
          addr_d  = ADDR_MAX;
        end else begin
          state_d = M2_R;
          addr_d  = addr_q - 1'b1;
        end
      end
      M3_R: begin
        ram_addr = addr_q;
        pend_d   = 1'b1;
        exp_d    = '0;
        paddr_d  = addr_q;
        if (addr_q == '0) state_d = DRAIN;
        else              addr_d  = addr_q - 1'b1;
      end
      DRAIN: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;
  assign fail_addr = faddr_q;
  assign fail_data = fdata_q;

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist: fault-free, stuck-bit and all-ones RAM models,
// mid-run reset and held start, with the March C-lite access sequence checked per cycle.
module tb_ram_bist;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       busy, done, pass;
  logic [5:0] err_count;
  logic [3:0] fail_addr;
  logic [7:0] fail_data;

  int n_checks = 0;
  int n_fail   = 0;
  int fault_mode = 0;  // 0 none, 1 bit3 stuck-1 at addr 5, 2 all reads 8'hFF

  logic [7:0] mem [16];

  ram_bist #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    logic [7:0] f;
    f = 8'h00;
    if (fault_mode == 1 && ram_addr == 4'd5) f = 8'h08;
    if (fault_mode == 2) f = 8'hFF;
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr] | f;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {we, addr, wdata} expected in busy cycle c (1..97) of a run.
  function automatic logic [12:0] exp_vec(input int c);
    int k;
    logic we;
    logic [3:0] a;
    logic [7:0] d;
    we = 1'b0; a = 4'd0; d = 8'd0;
    if (c <= 16) begin
      we = 1'b1; a = 4'(c - 1);
    end else if (c <= 48) begin
      k = c - 17; a = 4'(k / 2); we = (k % 2) == 1; d = we ? 8'hFF : 8'h00;
    end else if (c <= 80) begin
      k = c - 49; a = 4'(15 - k / 2); we = (k % 2) == 1;
    end else if (c <= 96) begin
      a = 4'(15 - (c - 81));
    end
    return {we, a, d};
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({ram_we, ram_addr, ram_wdata, busy, done, pass, err_count, fail_addr, fail_data});
  endfunction

  // Caller has start high in the current cycle (cycle 0); runs cycles 1..98.
  task automatic run_body(input bit hold);
    for (int c = 1; c <= 98; c++) begin
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      @(negedge clk);
      if (c == 1) check("clear_on_start", {58'd0, done, pass, err_count}, 64'd0);
      if (c <= 97)
        check($sformatf("seq_c%0d", c), {50'd0, busy, exp_vec(c)}, {50'd0, 1'b1, exp_vec(c)});
      else
        check("done_c98", {62'd0, busy, done}, 64'd1);
    end
  endtask

  task automatic do_run(input int mode, input bit hold);
    fault_mode = mode;
    @(posedge clk); #1;
    start = 1'b1;
    run_body(hold);
  endtask

  task automatic check_result(input string tag, input bit p, input int e,
                              input logic [3:0] fa, input logic [7:0] fd);
    check({tag, "_pass"}, 64'(pass), 64'(p));
    check({tag, "_err"},  64'(err_count), 64'(e));
    check({tag, "_faddr"}, 64'(fail_addr), 64'(fa));
    check({tag, "_fdata"}, 64'(fail_data), 64'(fd));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b1;
    #1 check("reset_outs", all_outs(), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_outs", all_outs(), 64'd0);

    do_run(0, 1'b0);
    check_result("clean", 1'b1, 0, 4'd0, 8'h00);
    repeat (3) @(negedge clk);
    check("done_sticky", {62'd0, busy, done}, 64'd1);

    do_run(1, 1'b0);
    check_result("stuck5", 1'b0, 2, 4'd5, 8'h08);

    // 16 mismatching r0 in M1 and 16 in M3; r1 in M2 reads match.
    do_run(2, 1'b0);
    check_result("ones", 1'b0, 32, 4'd0, 8'hFF);

    fault_mode = 0;
    @(posedge clk); #1 start = 1'b1;
    for (int c = 1; c < 40; c++) begin
      @(posedge clk); #1 start = 1'b0;
    end
    @(negedge clk);
    check("midrun_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1 check("rst_async", all_outs(), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_idle", all_outs(), 64'd0);
    do_run(0, 1'b0);
    check_result("after_rst", 1'b1, 0, 4'd0, 8'h00);

    // Held start: first run with fault, then a back-to-back run from DONE.
    do_run(1, 1'b1);
    check_result("hold1", 1'b0, 2, 4'd5, 8'h08);
    fault_mode = 0;
    run_body(1'b0);
    check_result("hold2", 1'b1, 0, 4'd0, 8'h00);
    repeat (2) @(negedge clk);
    check("final_idle_done", {62'd0, busy, done}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
